// File: rtl/regfile_pkg.sv
// Shared constants, types and the read-port forwarding select for the
// multi-port scoreboarded register file.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    // Source chosen by a read port.
    typedef enum logic [1:0] {
        RF_SEL_ARRAY = 2'd0,
        RF_SEL_WD0   = 2'd1,
        RF_SEL_WD1   = 2'd2,
        RF_SEL_ZERO  = 2'd3
    } rf_sel_e;

    // Priority bypass select: hardwired zero, then load writeback (port 1),
    // then ALU writeback (port 0), then the stored value. The hit flags are
    // already qualified by the caller, so this works for any data width.
    function automatic rf_sel_e rf_fwd(input logic zero_hit,
                                       input logic hit1,
                                       input logic hit0);
        rf_sel_e sel;
        if (zero_hit) begin
            sel = RF_SEL_ZERO;
        end else if (hit1) begin
            sel = RF_SEL_WD1;
        end else if (hit0) begin
            sel = RF_SEL_WD0;
        end else begin
            sel = RF_SEL_ARRAY;
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by an issued load
// and cleared by any writeback to that register. A set on the same edge as a
// clear wins, so a newly issued load is never lost.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_wa0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_wa1,
    input  logic              i_sb_set,
    input  logic [ADDR_W-1:0] i_sb_addr,
    input  logic [ADDR_W-1:0] i_a1,
    input  logic [ADDR_W-1:0] i_a2,
    output logic              o_busy1,
    output logic              o_busy2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                // Register 0 never has an outstanding load.
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_normal
                logic w_set;
                logic w_clr;
                assign w_set = i_sb_set && (i_sb_addr == ADDR_W'(gi));
                assign w_clr = (i_we0 && (i_wa0 == ADDR_W'(gi))) ||
                               (i_we1 && (i_wa1 == ADDR_W'(gi)));
                assign w_busy_next[gi] = w_set ? 1'b1 :
                                         (w_clr ? 1'b0 : r_busy[gi]);
            end
        end
    endgenerate

    // Busy vector register; reset clears every pending mark.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Raw lookups; bit 0 is already held at 0 when register 0 is hardwired.
    always_comb begin
        o_busy1 = r_busy[i_a1];
        o_busy2 = r_busy[i_a2];
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Two-read / two-write register file for the tinymips pipeline with optional
// hardwired r0, same-cycle write-to-read bypass and a pending-load scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              BUSY1,
    output logic              BUSY2,
    input  logic [ADDR_W-1:0] WA0,
    input  logic [DATA_W-1:0] WD0,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD1,
    input  logic              WE1,
    input  logic              SB_SET,
    input  logic [ADDR_W-1:0] SB_ADDR
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic ZERO_EN = (ZERO_REG != 0);
    localparam logic BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0] r_mem [NREGS];

    // Storage: reset clears everything; port 1 overrides port 0 on the same
    // address; a hardwired r0 stays at zero regardless of writes.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (ZERO_EN && (i == 0)) begin
                    r_mem[i] <= '0;
                end else if (WE1 && (WA1 == ADDR_W'(i))) begin
                    r_mem[i] <= WD1;
                end else if (WE0 && (WA0 == ADDR_W'(i))) begin
                    r_mem[i] <= WD0;
                end
            end
        end
    end

    // Per-port hit decode used by both the data bypass and the busy masking.
    logic w_zero1, w_zero2;
    logic w_hit1_p0, w_hit1_p1, w_hit2_p0, w_hit2_p1;

    assign w_zero1   = ZERO_EN && (A1 == '0);
    assign w_zero2   = ZERO_EN && (A2 == '0);
    assign w_hit1_p0 = BYP_EN && WE0 && (WA0 == A1);
    assign w_hit1_p1 = BYP_EN && WE1 && (WA1 == A1);
    assign w_hit2_p0 = BYP_EN && WE0 && (WA0 == A2);
    assign w_hit2_p1 = BYP_EN && WE1 && (WA1 == A2);

    rf_sel_e w_sel1, w_sel2;
    assign w_sel1 = rf_fwd(w_zero1, w_hit1_p1, w_hit1_p0);
    assign w_sel2 = rf_fwd(w_zero2, w_hit2_p1, w_hit2_p0);

    // Read port 1 data mux.
    always_comb begin
        RD1 = r_mem[A1];
        case (w_sel1)
            RF_SEL_ZERO: RD1 = '0;
            RF_SEL_WD1:  RD1 = WD1;
            RF_SEL_WD0:  RD1 = WD0;
            default:     RD1 = r_mem[A1];
        endcase
    end

    // Read port 2 data mux.
    always_comb begin
        RD2 = r_mem[A2];
        case (w_sel2)
            RF_SEL_ZERO: RD2 = '0;
            RF_SEL_WD1:  RD2 = WD1;
            RF_SEL_WD0:  RD2 = WD0;
            default:     RD2 = r_mem[A2];
        endcase
    end

    logic w_sb_busy1, w_sb_busy2;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_we0     (WE0),
        .i_wa0     (WA0),
        .i_we1     (WE1),
        .i_wa1     (WA1),
        .i_sb_set  (SB_SET),
        .i_sb_addr (SB_ADDR),
        .i_a1      (A1),
        .i_a2      (A2),
        .o_busy1   (w_sb_busy1),
        .o_busy2   (w_sb_busy2)
    );

    // A writeback arriving this cycle resolves the hazard when it is forwarded.
    always_comb begin
        BUSY1 = w_sb_busy1 && !(w_hit1_p0 || w_hit1_p1);
        BUSY2 = w_sb_busy2 && !(w_hit2_p0 || w_hit2_p1);
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a bypassing instance and a non-bypassing
// instance share the same stimulus; expected values are hand-computed.
module tb_regfile_mp_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  a1, a2, wa0, wa1, sb_addr;
    logic [31:0] wd0, wd1;
    logic        we0, we1, sb_set;
    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        busy1, busy2, nb_busy1, nb_busy2;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .CLK(clk), .RST_N(rst_n), .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
        .BUSY1(busy1), .BUSY2(busy2), .WA0(wa0), .WD0(wd0), .WE0(we0),
        .WA1(wa1), .WD1(wd1), .WE1(we1), .SB_SET(sb_set), .SB_ADDR(sb_addr)
    );

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .CLK(clk), .RST_N(rst_n), .A1(a1), .A2(a2), .RD1(nb_rd1), .RD2(nb_rd2),
        .BUSY1(nb_busy1), .BUSY2(nb_busy2), .WA0(wa0), .WD0(wd0), .WE0(we0),
        .WA1(wa1), .WD1(wd1), .WE1(we1), .SB_SET(sb_set), .SB_ADDR(sb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; sb_set = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; sb_addr = '0;
    endtask

    initial begin
        rst_n = 1'b0; a1 = '0; a2 = '0;
        idle();
        tick();
        rst_n = 1'b1;
        a1 = 5'd5; #1;
        check_eq("reset_rd1_r5", rd1, 32'h0);

        // Write r5 and mark r12 busy, then reset.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1234;
        sb_set = 1'b1; sb_addr = 5'd12;
        tick();
        idle();
        a1 = 5'd5; a2 = 5'd12; #1;
        check_eq("pre_rst_rd1_r5", rd1, 32'h1234);
        check_eq("pre_rst_busy2_r12", {31'b0, busy2}, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; #1;
        check_eq("post_rst_rd1_r5", rd1, 32'h0);
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); #1;
            check_eq($sformatf("post_rst_busy1_r%0d", i), {31'b0, busy1}, 32'h0);
        end

        // Hardwired zero register.
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; a1 = 5'd0; #1;
        check_eq("zero_same_cycle", rd1, 32'h0);
        check_eq("zero_same_cycle_nb", nb_rd1, 32'h0);
        tick();
        idle(); #1;
        check_eq("zero_next_cycle", rd1, 32'h0);
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        idle(); #1;
        check_eq("zero_busy1", {31'b0, busy1}, 32'h0);

        // Bypass and write-port priority.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        tick();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAA;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hBB;
        a1 = 5'd7; a2 = 5'd7; #1;
        check_eq("byp_rd1", rd1, 32'hBB);
        check_eq("byp_rd2", rd2, 32'hBB);
        check_eq("nobyp_rd1", nb_rd1, 32'h11);
        check_eq("nobyp_rd2", nb_rd2, 32'h11);
        tick();
        idle(); #1;
        check_eq("prio_stored", rd1, 32'hBB);
        check_eq("prio_stored_nb", nb_rd1, 32'hBB);

        // Scoreboard lifecycle on r9.
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        idle();
        a1 = 5'd9;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq($sformatf("sb_busy_idle%0d", c), {31'b0, busy1}, 32'h1);
            tick();
        end
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h55; #1;
        check_eq("sb_wb_busy1", {31'b0, busy1}, 32'h0);
        check_eq("sb_wb_rd1", rd1, 32'h55);
        check_eq("sb_wb_busy1_nb", {31'b0, nb_busy1}, 32'h1);
        check_eq("sb_wb_rd1_nb", nb_rd1, 32'h0);
        tick();
        idle(); #1;
        check_eq("sb_after_busy1", {31'b0, busy1}, 32'h0);
        check_eq("sb_after_busy1_nb", {31'b0, nb_busy1}, 32'h0);
        check_eq("sb_after_rd1", rd1, 32'h55);

        // Set wins over a clear on the same register.
        sb_set = 1'b1; sb_addr = 5'd3;
        tick();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33;
        sb_set = 1'b1; sb_addr = 5'd3;
        tick();
        idle(); a1 = 5'd3; #1;
        check_eq("setwins_busy1", {31'b0, busy1}, 32'h1);
        check_eq("setwins_rd1", rd1, 32'h33);

        // Reset mid-operation overrides a write and a busy mark.
        sb_set = 1'b1; sb_addr = 5'd4;
        tick();
        idle(); a1 = 5'd4; #1;
        check_eq("midrst_pre_busy1", {31'b0, busy1}, 32'h1);
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h77;
        sb_set = 1'b1; sb_addr = 5'd4;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(); a1 = 5'd4; a2 = 5'd7; #1;
        check_eq("midrst_rd1_r4", rd1, 32'h0);
        check_eq("midrst_busy1_r4", {31'b0, busy1}, 32'h0);
        check_eq("midrst_rd2_r7", rd2, 32'h0);
        a1 = 5'd3; #1;
        check_eq("midrst_busy1_r3", {31'b0, busy1}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
